// File: rtl/sem_ring_pkg.sv
// sem_ring_pkg: slot-type codes, injection FSM encoding and the wake-entry
// record shared by the semaphore responder station and its wake FIFO.
package sem_ring_pkg;

  // Ring slot-type codes
  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [3:0] SLOT_PREQ  = 4'd9;
  localparam logic [3:0] SLOT_PFAIL = 4'd10;
  localparam logic [3:0] SLOT_VREQ  = 4'd11;
  localparam logic [3:0] SLOT_WAKE  = 4'd12;

  // Wake injection FSM states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_TOKEN = 2'd1,
    ST_WAIT_N     = 2'd2,
    ST_SEND       = 2'd3
  } inj_state_e;

  // One pending wake: which semaphore was released and which core sleeps on it
  typedef struct packed {
    logic [5:0] sem;
    logic [3:0] core;
  } wake_entry_t;

  // Saturating 16-bit increment for the statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sem_responder_if.sv
// sem_responder_if: ring-side slot bundle of the semaphore responder station.
// The master side (ring) drives the incoming slot and observes the outgoing one;
// the slave side (responder) does the opposite.
interface sem_responder_if;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SrcDestIn;
  logic [31:0] respRingOut;
  logic [3:0]  respSlotTypeOut;
  logic [3:0]  respSrcDestOut;
  logic        respDriveRing;

  modport master (
    output RingIn, SlotTypeIn, SrcDestIn,
    input  respRingOut, respSlotTypeOut, respSrcDestOut, respDriveRing
  );

  modport slave (
    input  RingIn, SlotTypeIn, SrcDestIn,
    output respRingOut, respSlotTypeOut, respSrcDestOut, respDriveRing
  );
endinterface

// File: rtl/sem_wake_fifo.sv
// sem_wake_fifo: small synchronous FIFO of pending wake entries with a
// first-word-fall-through head. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module sem_wake_fifo
  import sem_ring_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  wake_entry_t data_i,
  input  logic        pop_i,
  output wake_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  wake_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Storage array write; contents need no reset since count_q qualifies them
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW + 1)'(1'b1);
        2'b01:   count_q <= count_q - (AW + 1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sem_responder.sv
// sem_responder: central semaphore responder on the slot ring.
// Snoops Preq/Pfail/Vreq slots, keeps owner and waiter tables for 64
// semaphores, turns refused Preqs into Pfail, and injects Wake slots for the
// recorded waiter when a semaphore is released (joining the token train).
// Optional build macro SEM_RESP_STATS_EN enables the grant/fail counters;
// without it both counters read 16'h0000.
module sem_responder
  import sem_ring_pkg::*;
#(
  parameter logic [3:0] MY_ID      = 4'd15,
  parameter int         WAKE_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  sem_responder_if.slave        ring,
  output logic                  respWaiting,
  output logic                  wakeOverflow,
  output logic [15:0]           grantCount,
  output logic [15:0]           failCount
);

  // Semaphore tables, one entry per semaphore number
  logic [63:0]      held_q;
  logic [63:0][3:0] owner_core_q;
  logic [63:0]      waiter_valid_q;
  logic [63:0][3:0] waiter_core_q;

  // Injection FSM
  inj_state_e state_q;
  logic [7:0] burst_q;
  logic       resp_waiting_q;
  logic       wake_overflow_q;

  // Decode of the current slot
  logic [5:0]  sem_s;
  logic        from_me_s;
  logic        is_preq_s;
  logic        is_pfail_s;
  logic        is_vreq_s;
  logic        token_s;
  logic        grant_s;
  logic        fail_s;
  logic        record_waiter_s;
  logic        release_s;
  logic        push_req_s;
  logic        pop_s;
  logic        overflow_s;
  wake_entry_t push_entry_s;
  wake_entry_t head_entry_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  // Ring outputs
  logic [31:0] ring_out_s;
  logic [3:0]  type_out_s;
  logic [3:0]  sd_out_s;
  logic        drive_s;

  assign sem_s      = ring.RingIn[5:0];
  assign from_me_s  = (ring.SrcDestIn == MY_ID);
  assign is_preq_s  = (ring.SlotTypeIn == SLOT_PREQ)  && !from_me_s;
  assign is_pfail_s = (ring.SlotTypeIn == SLOT_PFAIL) && !from_me_s;
  assign is_vreq_s  = (ring.SlotTypeIn == SLOT_VREQ)  && !from_me_s;
  assign token_s    = (ring.SlotTypeIn == SLOT_TOKEN);

  // Semaphores are non-reentrant: any Preq on a held semaphore fails
  assign grant_s         = is_preq_s && !held_q[sem_s];
  assign fail_s          = is_preq_s &&  held_q[sem_s];
  assign record_waiter_s = fail_s || is_pfail_s;
  assign release_s       = is_vreq_s && held_q[sem_s] &&
                           (ring.SrcDestIn == owner_core_q[sem_s]);
  assign push_req_s      = release_s && waiter_valid_q[sem_s];
  assign pop_s           = (state_q == ST_SEND);
  assign overflow_s      = push_req_s && fifo_full_s && !pop_s;

  assign push_entry_s.sem  = sem_s;
  assign push_entry_s.core = waiter_core_q[sem_s];

  sem_wake_fifo #(
    .DEPTH (WAKE_DEPTH)
  ) u_wake_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push_req_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_entry_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Owner and waiter table updates from snooped Preq/Pfail/Vreq slots
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_q         <= '0;
      owner_core_q   <= '0;
      waiter_valid_q <= '0;
      waiter_core_q  <= '0;
    end else begin
      if (grant_s) begin
        held_q[sem_s]       <= 1'b1;
        owner_core_q[sem_s] <= ring.SrcDestIn;
      end else if (release_s) begin
        held_q[sem_s] <= 1'b0;
      end
      // Last failer wins; the waiter is consumed on release even if the wake is dropped
      if (record_waiter_s) begin
        waiter_valid_q[sem_s] <= 1'b1;
        waiter_core_q[sem_s]  <= ring.SrcDestIn;
      end else if (release_s) begin
        waiter_valid_q[sem_s] <= 1'b0;
      end
    end
  end

  // Sticky flag for a wake lost to a full FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wake_overflow_q <= 1'b0;
    end else if (overflow_s) begin
      wake_overflow_q <= 1'b1;
    end
  end

  // Wake injection FSM: wait for the token, ride behind the train, then send
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      burst_q        <= 8'd0;
      resp_waiting_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_q        <= ST_WAIT_TOKEN;
            resp_waiting_q <= 1'b1;
          end
        end
        ST_WAIT_TOKEN: begin
          if (token_s) begin
            resp_waiting_q <= 1'b0;
            if (ring.RingIn[7:0] == 8'd0) begin
              state_q <= ST_SEND;
            end else begin
              burst_q <= ring.RingIn[7:0];
              state_q <= ST_WAIT_N;
            end
          end
        end
        ST_WAIT_N: begin
          // Leave once the decremented length reaches 1 so the Wake lands
          // exactly burstLength slots after the token
          burst_q <= burst_q - 8'd1;
          if (burst_q <= 8'd2) begin
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q        <= ST_IDLE;
          resp_waiting_q <= 1'b0;
        end
      endcase
    end
  end

  // Ring output selection: Wake injection, token join, orphan reclaim, Pfail, else pass
  always_comb begin
    ring_out_s = ring.RingIn;
    type_out_s = ring.SlotTypeIn;
    sd_out_s   = ring.SrcDestIn;
    drive_s    = 1'b0;
    if (!reset) begin
      drive_s = 1'b0;
    end else if (state_q == ST_SEND) begin
      ring_out_s = {26'b0, head_entry_s.sem};
      type_out_s = SLOT_WAKE;
      sd_out_s   = head_entry_s.core;
      drive_s    = 1'b1;
    end else if ((state_q == ST_WAIT_TOKEN) && token_s) begin
      ring_out_s = ring.RingIn + 32'd1;
      drive_s    = 1'b1;
    end else if (from_me_s && (ring.SlotTypeIn == SLOT_WAKE)) begin
      type_out_s = SLOT_NULL;
      drive_s    = 1'b1;
    end else if (fail_s) begin
      type_out_s = SLOT_PFAIL;
      drive_s    = 1'b1;
    end else begin
      drive_s = 1'b0;
    end
  end

  assign ring.respRingOut     = ring_out_s;
  assign ring.respSlotTypeOut = type_out_s;
  assign ring.respSrcDestOut  = sd_out_s;
  assign ring.respDriveRing   = drive_s;
  assign respWaiting          = resp_waiting_q;
  assign wakeOverflow         = wake_overflow_q;

`ifdef SEM_RESP_STATS_EN
  logic [15:0] grant_count_q;
  logic [15:0] fail_count_q;

  // Saturating Preq grant/fail statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_count_q <= 16'h0000;
      fail_count_q  <= 16'h0000;
    end else begin
      if (grant_s) begin
        grant_count_q <= sat_inc16(grant_count_q);
      end
      if (fail_s) begin
        fail_count_q <= sat_inc16(fail_count_q);
      end
    end
  end

  assign grantCount = grant_count_q;
  assign failCount  = fail_count_q;
`else
  assign grantCount = 16'h0000;
  assign failCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_sem_responder.sv
// tb_sem_responder: scenario-driven bench for the semaphore responder.
// Expected slot outputs are queued as each slot is driven; observed outputs
// are captured mid-cycle and compared in order at the end of each scenario.
module tb_sem_responder;
  import sem_ring_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  typ;
    logic [3:0]  sd;
    logic        drv;
  } obs_t;

  logic        clock;
  logic        reset;
  logic        respWaiting;
  logic        wakeOverflow;
  logic [15:0] grantCount;
  logic [15:0] failCount;

  sem_responder_if ring_if ();

  sem_responder #(
    .MY_ID      (4'd15),
    .WAKE_DEPTH (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ring         (ring_if),
    .respWaiting  (respWaiting),
    .wakeOverflow (wakeOverflow),
    .grantCount   (grantCount),
    .failCount    (failCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   exp_grants = 0;
  int   exp_fails  = 0;

  function automatic obs_t pass_o(input logic [3:0] t, input logic [3:0] sd, input logic [31:0] d);
    return {d, t, sd, 1'b0};
  endfunction

  function automatic obs_t drv_o(input logic [3:0] t, input logic [3:0] sd, input logic [31:0] d);
    return {d, t, sd, 1'b1};
  endfunction

  function automatic logic [15:0] stat_exp(input int v);
    logic [15:0] r;
    r = 16'(v);
`ifndef SEM_RESP_STATS_EN
    r = 16'h0000;
`endif
    return r;
  endfunction

  function automatic obs_t sample();
    return {ring_if.respRingOut, ring_if.respSlotTypeOut, ring_if.respSrcDestOut, ring_if.respDriveRing};
  endfunction

  task automatic cyc(input logic [3:0] t, input logic [3:0] sd, input logic [31:0] d, input obs_t e);
    ring_if.SlotTypeIn = t;
    ring_if.SrcDestIn  = sd;
    ring_if.RingIn     = d;
    exp_q.push_back(e);
    @(negedge clock);
    obs_q.push_back(sample());
    @(posedge clock);
    #1;
  endtask

  task automatic null_cyc();
    cyc(SLOT_NULL, 4'd0, 32'd0, pass_o(SLOT_NULL, 4'd0, 32'd0));
  endtask

  task automatic test_reset();
    obs_t e, o;
    reset = 1'b0;
    ring_if.SlotTypeIn = SLOT_TOKEN;
    ring_if.SrcDestIn  = 4'd3;
    ring_if.RingIn     = 32'h0000_1234;
    #12;
    exp_q.push_back(pass_o(SLOT_TOKEN, 4'd3, 32'h0000_1234));
    obs_q.push_back(sample());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_pass: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
    n_tests++;
    if ({respWaiting, wakeOverflow, grantCount, failCount} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_status: got waiting=%b ovf=%b grants=%0d fails=%0d, expected all 0", respWaiting, wakeOverflow, grantCount, failCount);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    null_cyc();
    void'(exp_q.pop_front()); void'(obs_q.pop_front());
  endtask

  task automatic test_grant();
    obs_t e, o;
    cyc(SLOT_PREQ, 4'd2, 32'd5, pass_o(SLOT_PREQ, 4'd2, 32'd5));
    exp_grants++;
    n_tests++;
    if (grantCount !== stat_exp(exp_grants)) begin
      n_fail++;
      $display("FAIL grant_count: got %0d expected %0d", grantCount, stat_exp(exp_grants));
    end
    null_cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL grant_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_fail_wake();
    obs_t e, o;
    cyc(SLOT_PREQ, 4'd3, 32'd5, drv_o(SLOT_PFAIL, 4'd3, 32'd5));
    exp_fails++;
    n_tests++;
    if (failCount !== stat_exp(exp_fails)) begin
      n_fail++;
      $display("FAIL fail_count: got %0d expected %0d", failCount, stat_exp(exp_fails));
    end
    cyc(SLOT_VREQ, 4'd2, 32'd5, pass_o(SLOT_VREQ, 4'd2, 32'd5));
    null_cyc();
    n_tests++;
    if (respWaiting !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_wake_waiting: got %b expected 1", respWaiting);
    end
    cyc(SLOT_TOKEN, 4'd0, 32'd0, drv_o(SLOT_TOKEN, 4'd0, 32'd1));
    cyc(SLOT_NULL, 4'd0, 32'd0, drv_o(SLOT_WAKE, 4'd3, 32'd5));
    null_cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fail_wake_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_bad_v();
    obs_t e, o;
    cyc(SLOT_VREQ, 4'd4, 32'd9, pass_o(SLOT_VREQ, 4'd4, 32'd9));
    cyc(SLOT_PREQ, 4'd2, 32'd5, pass_o(SLOT_PREQ, 4'd2, 32'd5));
    exp_grants++;
    cyc(SLOT_VREQ, 4'd4, 32'd5, pass_o(SLOT_VREQ, 4'd4, 32'd5));
    cyc(SLOT_PREQ, 4'd6, 32'd5, drv_o(SLOT_PFAIL, 4'd6, 32'd5));
    exp_fails++;
    n_tests++;
    if (respWaiting !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_v_waiting: got %b expected 0", respWaiting);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bad_v_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_train_wait();
    obs_t e, o;
    cyc(SLOT_VREQ, 4'd2, 32'd5, pass_o(SLOT_VREQ, 4'd2, 32'd5));
    null_cyc();
    cyc(SLOT_TOKEN, 4'd0, 32'h00AB_0003, drv_o(SLOT_TOKEN, 4'd0, 32'h00AB_0004));
    cyc(SLOT_NULL, 4'd9, 32'h77, pass_o(SLOT_NULL, 4'd9, 32'h77));
    cyc(SLOT_NULL, 4'd9, 32'h78, pass_o(SLOT_NULL, 4'd9, 32'h78));
    cyc(SLOT_NULL, 4'd0, 32'd0, drv_o(SLOT_WAKE, 4'd6, 32'd5));
    null_cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL train_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_own_slots();
    obs_t e, o;
    cyc(SLOT_WAKE, 4'd15, 32'h21, drv_o(SLOT_NULL, 4'd15, 32'h21));
    cyc(SLOT_WAKE, 4'd3, 32'h22, pass_o(SLOT_WAKE, 4'd3, 32'h22));
    cyc(SLOT_PREQ, 4'd15, 32'd7, pass_o(SLOT_PREQ, 4'd15, 32'd7));
    cyc(SLOT_PREQ, 4'd1, 32'd7, pass_o(SLOT_PREQ, 4'd1, 32'd7));
    exp_grants++;
    cyc(SLOT_PFAIL, 4'd4, 32'd7, pass_o(SLOT_PFAIL, 4'd4, 32'd7));
    cyc(SLOT_VREQ, 4'd1, 32'd7, pass_o(SLOT_VREQ, 4'd1, 32'd7));
    null_cyc();
    cyc(SLOT_TOKEN, 4'd0, 32'd0, drv_o(SLOT_TOKEN, 4'd0, 32'd1));
    cyc(SLOT_NULL, 4'd0, 32'd0, drv_o(SLOT_WAKE, 4'd4, 32'd7));
    null_cyc();
    n_tests++;
    if ({grantCount, failCount} !== {stat_exp(exp_grants), stat_exp(exp_fails)}) begin
      n_fail++;
      $display("FAIL own_slots_counts: got grants=%0d fails=%0d expected %0d %0d", grantCount, failCount, stat_exp(exp_grants), stat_exp(exp_fails));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL own_slots_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t e, o;
    logic [31:0] s;
    for (int i = 0; i < 5; i++) begin
      s = 32'(10 + i);
      cyc(SLOT_PREQ, 4'd1, s, pass_o(SLOT_PREQ, 4'd1, s));
      exp_grants++;
      cyc(SLOT_PREQ, 4'd2, s, drv_o(SLOT_PFAIL, 4'd2, s));
      exp_fails++;
      cyc(SLOT_VREQ, 4'd1, s, pass_o(SLOT_VREQ, 4'd1, s));
      if (i == 3) begin
        n_tests++;
        if (wakeOverflow !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow_early: got %b expected 0", wakeOverflow);
        end
      end
    end
    n_tests++;
    if (wakeOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b expected 1", wakeOverflow);
    end
    for (int i = 0; i < 4; i++) begin
      s = 32'(10 + i);
      cyc(SLOT_TOKEN, 4'd0, 32'd0, drv_o(SLOT_TOKEN, 4'd0, 32'd1));
      cyc(SLOT_NULL, 4'd0, 32'd0, drv_o(SLOT_WAKE, 4'd2, s));
      null_cyc();
    end
    cyc(SLOT_TOKEN, 4'd0, 32'd0, pass_o(SLOT_TOKEN, 4'd0, 32'd0));
    n_tests++;
    if ({respWaiting, grantCount, failCount} !== {1'b0, stat_exp(exp_grants), stat_exp(exp_fails)}) begin
      n_fail++;
      $display("FAIL overflow_status: got waiting=%b grants=%0d fails=%0d expected 0 %0d %0d", respWaiting, grantCount, failCount, stat_exp(exp_grants), stat_exp(exp_fails));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    cyc(SLOT_PREQ, 4'd1, 32'd30, pass_o(SLOT_PREQ, 4'd1, 32'd30));
    cyc(SLOT_PREQ, 4'd2, 32'd20, pass_o(SLOT_PREQ, 4'd2, 32'd20));
    cyc(SLOT_PREQ, 4'd3, 32'd20, drv_o(SLOT_PFAIL, 4'd3, 32'd20));
    cyc(SLOT_VREQ, 4'd2, 32'd20, pass_o(SLOT_VREQ, 4'd2, 32'd20));
    null_cyc();
    cyc(SLOT_TOKEN, 4'd0, 32'd5, drv_o(SLOT_TOKEN, 4'd0, 32'd6));
    null_cyc();
    #2;
    reset = 1'b0;
    ring_if.SlotTypeIn = SLOT_WAKE;
    ring_if.SrcDestIn  = 4'd15;
    ring_if.RingIn     = 32'h55;
    #1;
    exp_q.push_back(pass_o(SLOT_WAKE, 4'd15, 32'h55));
    obs_q.push_back(sample());
    n_tests++;
    if ({respWaiting, wakeOverflow, grantCount, failCount} !== 34'd0) begin
      n_fail++;
      $display("FAIL async_reset_status: got waiting=%b ovf=%b grants=%0d fails=%0d, expected all 0", respWaiting, wakeOverflow, grantCount, failCount);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    exp_grants = 0;
    exp_fails  = 0;
    null_cyc();
    cyc(SLOT_TOKEN, 4'd0, 32'd0, pass_o(SLOT_TOKEN, 4'd0, 32'd0));
    cyc(SLOT_PREQ, 4'd2, 32'd30, pass_o(SLOT_PREQ, 4'd2, 32'd30));
    exp_grants++;
    cyc(SLOT_PREQ, 4'd3, 32'd30, drv_o(SLOT_PFAIL, 4'd3, 32'd30));
    exp_fails++;
    n_tests++;
    if ({respWaiting, grantCount, failCount} !== {1'b0, stat_exp(exp_grants), stat_exp(exp_fails)}) begin
      n_fail++;
      $display("FAIL async_reset_after: got waiting=%b grants=%0d fails=%0d expected 0 %0d %0d", respWaiting, grantCount, failCount, stat_exp(exp_grants), stat_exp(exp_fails));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_reset_slot: got data=%h type=%0d sd=%0d drv=%b, expected data=%h type=%0d sd=%0d drv=%b", o.data, o.typ, o.sd, o.drv, e.data, e.typ, e.sd, e.drv);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b0;
    ring_if.SlotTypeIn = SLOT_NULL;
    ring_if.SrcDestIn  = 4'd0;
    ring_if.RingIn     = 32'd0;
    test_reset();
    test_grant();
    test_fail_wake();
    test_bad_v();
    test_train_wait();
    test_own_slots();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sem_responder.md
Name: sem_responder

Overview:
- Central semaphore responder station on the ring; answers Preq/Vreq traffic from the cores' semaphore units.
- Keeps an owner table for all 64 semaphores and decides grant or fail for each Preq.
- Records one waiting core per semaphore. When the semaphore is released, it injects a Wake slot to that core, sending it through the normal token/train mechanism.

Parameters:
- MY_ID, 15, ring station number of this responder (SrcDest value it ignores as requester).
- WAKE_DEPTH, 4, wake FIFO depth (power of two).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- RingIn  in  32  ring data; RingIn[5:0] is the semaphore number for Preq/Pfail/Vreq
- SlotTypeIn  in  4  incoming slot type
- SrcDestIn  in  4  requesting core for Preq/Pfail/Vreq
- respRingOut  out  32  ring data out
- respSlotTypeOut  out  4  slot type out
- respSrcDestOut  out  4  src/dest out
- respDriveRing  out  1  this station overrides ring outputs this cycle
- respWaiting  out  1  high in waitToken
- wakeOverflow  out  1  sticky; a wake was dropped because the FIFO was full
- grantCount  out  16  Preq grants (see Optional Feature)
- failCount  out  16  Preq fails (see Optional Feature)

Behaviour:
- Slot codes: Null=7, Token=1, Preq=9, Pfail=10, Vreq=11, Wake=12.
- Reset (reset low, asynchronous):
  - owner table all free; waiter table all invalid.
  - FIFO empty; state=idle; wakeOverflow=0; counters=0.
  - respDriveRing=0; respRingOut/respSlotTypeOut/respSrcDestOut pass inputs through.
- Owner table: 64 x {held, owner[3:0]}. Waiter table: 64 x {valid, core[3:0]}.
  - Both are read combinationally at RingIn[5:0] and written on the clock edge.
- Preq with SrcDestIn != MY_ID, semaphore s:
  - If not held: pass the slot unchanged (grant). Next edge: held=1, owner=SrcDestIn, grantCount+1.
  - If held, including by the same core (non-reentrant): drive respSlotTypeOut=Pfail, other fields unchanged. Next edge: waiter[s]={1,SrcDestIn} (last failer wins), failCount+1.
- Pfail arriving (another station already failed it): pass unchanged; record the waiter only.
- Vreq, SrcDestIn == owner[s] and held:
  - Next edge: held=0.
  - If waiter[s] is valid, push {s, waiter core} into the FIFO and clear waiter[s].
  - FIFO full: drop the entry, set wakeOverflow, still clear waiter[s].
- Vreq from a non-owner, or for a free semaphore: ignored, no table change.
- Slots with SrcDestIn == MY_ID: when the type is Wake, drive Null (orphaned wake reclaimed). Every other such slot passes unchanged.
- All other slot types: pass through, respDriveRing=0.
- Injection FSM (states idle, waitToken, waitN, send):
  - idle -> waitToken when the FIFO is not empty.
  - waitToken, SlotTypeIn==Token:
    - drive respRingOut=RingIn+1 with respDriveRing=1 (join the train);
    - if RingIn[7:0]==0 go to send; else latch burstLength=RingIn[7:0] and go to waitN.
  - waitN: decrement burstLength each cycle; go to send when burstLength==1.
  - send: drive SlotType=Wake, SrcDest=waiter core, RingOut={26'b0,s}; pop the FIFO; return to idle.
- A snooped Preq/Vreq in the same cycle as waitToken/waitN is still processed; table update and FIFO push coexist with a pop.
  - Push and pop in the same cycle when full: allowed, no overflow.
- Counters saturate at 16'hFFFF.
- reset asserted mid-train: return to idle immediately; the FIFO contents are lost.

Optional Feature:
- SEM_RESP_STATS_EN defined: grantCount/failCount implemented as described.
- Not defined: both tied to 16'h0000; counter logic absent.

Decomposition:
- Shared package sem_ring_pkg holds:
  - slot-type constants (Null, Token, Preq, Pfail, Vreq, Wake);
  - FSM state encoding;
  - wake-entry typedef {sem[5:0], core[3:0]}.
- One sub-module: sem_wake_fifo (synchronous FIFO, WAKE_DEPTH entries, full/empty flags, asynchronous active-low reset).

Test Plan:
- Grant: Preq s=5 from core 2 on a free table -> slot passes unchanged (type 9); owner[5]=2; grantCount=1.
- Fail and wake: core 3 sends Preq s=5 -> output type 10 and waiter[5]=3. Core 2 sends Vreq s=5 -> held cleared. Token with RingIn=0 -> respRingOut=1; next cycle Wake, dest 3, data 5.
- Train wait: Token with RingIn[7:0]=3 while the FIFO is not empty -> Wake is driven exactly 3 cycles after the Token.
- Bad V: Vreq s=5 from core 4 while owner=2 -> no change; later Preq from core 6 gets Pfail.
- Overflow: 5 wake-producing Vreqs with no Token -> 4 queued; wakeOverflow=1; exactly 4 Wakes emitted after Tokens.
- Async reset asserted in waitN -> idle; FIFO empty; outputs pass through; table all free.
